// File: rtl/shared_mult_arbiter.sv
// Round-robin arbiter that time-shares one external combinational 32-bit multiplier among
// NUM_REQ requesters and holds each registered product, tagged with its owner, until consumed.
module shared_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*32-1:0]   i_req_left,
  input  logic [NUM_REQ*32-1:0]   i_req_right,
  output logic                    o_unit_go,
  output logic [31:0]             o_unit_left,
  output logic [31:0]             o_unit_right,
  input  logic [31:0]             i_unit_out,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [ID_W-1:0]         o_resp_id,
  output logic [31:0]             o_resp_data
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_resp_id;
  logic [31:0]     r_resp_data;

  logic            w_can_issue;
  logic            w_found;
  logic            w_grant;
  logic [ID_W-1:0] w_grant_idx;
  logic [ID_W-1:0] w_sel;
  logic [ID_W-1:0] w_next_ptr;
  logic [31:0]     w_left_arr  [NUM_REQ];
  logic [31:0]     w_right_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_left_arr[g]  = i_req_left[32*g +: 32];
    assign w_right_arr[g] = i_req_right[32*g +: 32];
  end

  assign o_resp_valid = (r_state == FULL);
  assign o_resp_id    = r_resp_id;
  assign o_resp_data  = r_resp_data;
  assign w_can_issue  = !o_resp_valid || i_resp_ready;

  // Rotating priority search starting at the pointer; first valid requester wins.
  always_comb begin
    int              v_int;
    logic [ID_W-1:0] v_sel;
    w_found     = 1'b0;
    w_grant_idx = '0;
    v_int       = 0;
    v_sel       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_int = (int'(r_ptr) + k) % NUM_REQ;
      v_sel = ID_W'(v_int);
      if (!w_found && i_req_valid[v_sel]) begin
        w_found     = 1'b1;
        w_grant_idx = v_sel;
      end else begin
        w_found     = w_found;
      end
    end
  end

  assign w_grant = w_can_issue && w_found && !i_reset;

  // One-hot grant, operand steering and next pointer derived from the winner.
  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = w_grant && (w_grant_idx == ID_W'(i));
    end
    if (w_grant) begin
      w_sel = w_grant_idx;
    end else begin
      w_sel = r_ptr;
    end
    if (w_grant_idx == ID_W'(NUM_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_grant_idx + ID_W'(1);
    end
  end

  assign o_unit_go    = |o_req_ready;
  assign o_unit_left  = w_left_arr[w_sel];
  assign o_unit_right = w_right_arr[w_sel];

  // Result slot FSM: a grant always refills the slot, even while draining the old result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= EMPTY;
      r_ptr       <= '0;
      r_resp_id   <= '0;
      r_resp_data <= 32'd0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_grant) begin
            r_state <= FULL;
          end else begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (!w_grant && i_resp_ready) begin
            r_state <= EMPTY;
          end else begin
            r_state <= FULL;
          end
        end
        default: r_state <= EMPTY;
      endcase
      if (w_grant) begin
        r_resp_data <= i_unit_out;
        r_resp_id   <= w_grant_idx;
        r_ptr       <= w_next_ptr;
      end else begin
        r_resp_data <= r_resp_data;
        r_resp_id   <= r_resp_id;
        r_ptr       <= r_ptr;
      end
    end
  end

endmodule

// File: tb/tb_shared_mult_arbiter.sv
// Scoreboard bench for shared_mult_arbiter: the driver pushes hand-computed {id, product}
// pairs on each expected grant; a monitor pops and compares whenever a result is consumed.
module tb_shared_mult_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_left;
  logic [127:0] req_right;
  logic         unit_go;
  logic [31:0]  unit_left;
  logic [31:0]  unit_right;
  logic [31:0]  unit_out;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [31:0]  resp_data;

  int           n_vec = 0;
  int           n_err = 0;
  logic [33:0]  sb_q [$];
  logic [33:0]  mon_exp;

  always #5 clk = ~clk;

  assign unit_out = unit_left * unit_right;

  shared_mult_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_left   (req_left),
    .i_req_right  (req_right),
    .o_unit_go    (unit_go),
    .o_unit_left  (unit_left),
    .o_unit_right (unit_right),
    .i_unit_out   (unit_out),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_id    (resp_id),
    .o_resp_data  (resp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result must match the oldest expected entry.
  always @(negedge clk) begin
    if (resp_valid === 1'b1 && resp_ready === 1'b1 && reset === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got id %0d data %0h expected no result", resp_id, resp_data);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("resp_id", {62'd0, resp_id}, {62'd0, mon_exp[33:32]});
        chk("resp_data", {32'd0, resp_data}, {32'd0, mon_exp[31:0]});
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] l, input logic [31:0] r);
    req_left[i*32 +: 32]  = l;
    req_right[i*32 +: 32] = r;
  endtask

  // One cycle: check grant/valid mid-cycle, queue expected result if granting, advance.
  task automatic cyc(input logic [3:0] er, input logic ev, input logic [1:0] eid, input logic [31:0] ed);
    @(negedge clk);
    chk("req_ready", {60'd0, req_ready}, {60'd0, er});
    chk("unit_go", {63'd0, unit_go}, {63'd0, (er != 4'd0)});
    chk("resp_valid", {63'd0, resp_valid}, {63'd0, ev});
    if (er != 4'd0) sb_q.push_back({eid, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic stall_cyc();
    @(negedge clk);
    chk("stall_req_ready", {60'd0, req_ready}, 64'd0);
    chk("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("stall_resp_id", {62'd0, resp_id}, 64'd1);
    chk("stall_resp_data", {32'd0, resp_data}, 64'd42);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    req_left  = 128'd0;
    req_right = 128'd0;
    do_reset();

    @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_id", {62'd0, resp_id}, 64'd0);
    chk("rst_resp_data", {32'd0, resp_data}, 64'd0);
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    @(posedge clk);
    #1;

    // Single request, 3*5
    resp_ready = 1'b1;
    set_op(0, 32'd3, 32'd5);
    req_valid = 4'b0001;
    cyc(4'b0001, 1'b0, 2'd0, 32'd15);
    req_valid = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd0, 32'd0);

    // All requesting from ptr=0: grants 0,1,2,3,0 back to back
    do_reset();
    resp_ready = 1'b1;
    set_op(0, 32'd2, 32'd10);
    set_op(1, 32'd3, 32'd10);
    set_op(2, 32'd4, 32'd10);
    set_op(3, 32'd5, 32'd10);
    req_valid = 4'b1111;
    cyc(4'b0001, 1'b0, 2'd0, 32'd20);
    cyc(4'b0010, 1'b1, 2'd1, 32'd30);
    cyc(4'b0100, 1'b1, 2'd2, 32'd40);
    cyc(4'b1000, 1'b1, 2'd3, 32'd50);
    cyc(4'b0001, 1'b1, 2'd0, 32'd20);
    req_valid = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd0, 32'd0);

    // Stall with a result held, then release grants next in rotation
    resp_ready = 1'b0;
    set_op(1, 32'd7, 32'd6);
    req_valid = 4'b0010;
    cyc(4'b0010, 1'b0, 2'd1, 32'd42);
    req_valid = 4'b1111;
    repeat (5) stall_cyc();
    resp_ready = 1'b1;
    cyc(4'b0100, 1'b1, 2'd2, 32'd40);
    req_valid = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd0, 32'd0);

    // Product wraps modulo 2^32
    set_op(3, 32'hFFFF_FFFF, 32'd2);
    req_valid = 4'b1000;
    cyc(4'b1000, 1'b0, 2'd3, 32'hFFFF_FFFE);
    req_valid = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd0, 32'd0);

    // Move ptr to 2, then requests from 0 and 3 only
    req_valid = 4'b0010;
    cyc(4'b0010, 1'b0, 2'd1, 32'd42);
    set_op(0, 32'd3, 32'd5);
    req_valid = 4'b1001;
    cyc(4'b1000, 1'b1, 2'd3, 32'hFFFF_FFFE);
    req_valid = 4'b0001;
    cyc(4'b0001, 1'b1, 2'd0, 32'd15);
    req_valid = 4'b0010;
    cyc(4'b0010, 1'b1, 2'd1, 32'd42);
    req_valid = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd0, 32'd0);

    // Reset while FULL with requests pending
    resp_ready = 1'b0;
    req_valid = 4'b0100;
    cyc(4'b0100, 1'b0, 2'd2, 32'd40);
    reset = 1'b1;
    req_valid = 4'b1111;
    sb_q.delete();
    cyc(4'b0000, 1'b1, 2'd0, 32'd0);
    cyc(4'b0000, 1'b0, 2'd0, 32'd0);
    reset = 1'b0;
    resp_ready = 1'b1;
    req_valid = 4'b1010;
    cyc(4'b0010, 1'b0, 2'd1, 32'd42);
    req_valid = 4'b0000;
    cyc(4'b0000, 1'b1, 2'd0, 32'd0);
    cyc(4'b0000, 1'b0, 2'd0, 32'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
